// File: rtl/cpy_alu_pkg.sv
// Shared definitions for the sequenced ALU: op-select codes, FSM states, default width.
// No logic here; imported by the top and the iterative datapath.
package cpy_alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cpy_alu_iter.sv
// Iterative datapath: shift-left one bit per step, or shift-add multiply (CPY_ALU_MUL_EN) one opB bit per step.
// Latency: n steps for SHL, WIDTH steps for MUL; done is high during the final step with next-state results on res/c/v.
// Backpressure: none; the caller only asserts step while it is waiting on this unit.
module cpy_alu_iter
    import cpy_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             elk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             c,
    output logic             v
);

    localparam int CW = SHW + 1;

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] step_sh;
    logic             step_c;
    logic             step_v;

`ifdef CPY_ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             mul_q, mul_d;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH:0]   sum;
`else
    logic unused_mul;
    assign unused_mul = ^{is_mul, b};
`endif

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        step_sh = sh_q << 1;
        step_c  = sh_q[WIDTH-1];
        step_v  = 1'b0;
`ifdef CPY_ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mul_d    = mul_q;
        step_acc = acc_q;
        // Product lives in {acc, sh}; sh starts as the multiplier and drains LSB-first.
        sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
        if (mul_q) begin
            step_acc = sum[WIDTH:1];
            step_sh  = {sum[0], sh_q[WIDTH-1:1]};
            step_c   = |step_acc;
            step_v   = |step_acc;
        end
        if (start) begin
            acc_d   = '0;
            mcand_d = a;
            mul_d   = is_mul;
        end else if (step && cnt_q != '0) begin
            acc_d = step_acc;
        end
`endif
        if (start) begin
            sh_d  = a;
            cnt_d = {1'b0, shamt};
`ifdef CPY_ALU_MUL_EN
            if (is_mul) begin
                sh_d  = b;
                cnt_d = CW'(WIDTH);
            end
`endif
        end else if (step && cnt_q != '0) begin
            sh_d  = step_sh;
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign done = step && (cnt_q == CW'(1));
    assign res  = step_sh;
    assign c    = step_c;
    assign v    = step_v;

    always_ff @(posedge elk) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
`ifdef CPY_ALU_MUL_EN
            acc_q   <= '0;
            mcand_q <= '0;
            mul_q   <= 1'b0;
`endif
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`ifdef CPY_ALU_MUL_EN
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mul_q   <= mul_d;
`endif
        end
    end

endmodule

// File: rtl/cpy_alu_seq.sv
// Handshaked ALU: 6 single-cycle ops plus iterative SHL and MUL (MUL iterative only with CPY_ALU_MUL_EN).
// Latency accept->out_valid: 1 cycle single ops / SHL n=0, n+1 for SHL, WIDTH+1 for MUL.
// Backpressure: result held while out_ready low; in DONE a new request is taken only alongside out_ready.
module cpy_alu_seq
    import cpy_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             elk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic             needs_iter;
    logic             accept;
    logic             iter_start, iter_step, iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_c, iter_v;

    assign shamt = opB[SHW-1:0];

    always_comb begin
        add_w  = {1'b0, opA} + {1'b0, opB};
        sub_w  = {1'b0, opA} - {1'b0, opB};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (sel)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (opA[WIDTH-1] == opB[WIDTH-1]) && (add_w[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = (opA[WIDTH-1] != opB[WIDTH-1]) && (sub_w[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_AND:  sc_res = opA & opB;
            OP_OR:   sc_res = opA | opB;
            OP_NOT:  sc_res = ~opA;
            OP_XOR:  sc_res = opA ^ opB;
            OP_SHL:  sc_res = opA;   // only reached here with a zero shift amount
            default: sc_res = '0;    // MUL without the multiplier datapath
        endcase
    end

`ifdef CPY_ALU_MUL_EN
    assign needs_iter = ((sel == OP_SHL) && (shamt != '0)) || (sel == OP_MUL);
`else
    assign needs_iter = (sel == OP_SHL) && (shamt != '0);
`endif

    always_comb begin
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept    = in_valid && in_ready;
    assign iter_step = (state_q == ST_BUSY);
    assign out_valid = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        z_d        = z_q;
        c_d        = c_q;
        v_d        = v_q;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                    res_d   = iter_res;
                    z_d     = (iter_res == '0);
                    c_d     = iter_c;
                    v_d     = iter_v;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Acceptance is only possible from IDLE or from DONE while the result drains.
        if (accept) begin
            if (needs_iter) begin
                state_d    = ST_BUSY;
                iter_start = 1'b1;
            end else begin
                state_d = ST_DONE;
                res_d   = sc_res;
                z_d     = (sc_res == '0);
                c_d     = sc_c;
                v_d     = sc_v;
            end
        end
    end

    always_ff @(posedge elk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign res = res_q;
    assign z   = z_q;
    assign c   = c_q;
    assign v   = v_q;

    cpy_alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .elk    (elk),
        .rst    (rst),
        .start  (iter_start),
        .step   (iter_step),
        .is_mul (sel == OP_MUL),
        .a      (opA),
        .b      (opB),
        .shamt  (shamt),
        .done   (iter_done),
        .res    (iter_res),
        .c      (iter_c),
        .v      (iter_v)
    );

endmodule

// File: tb/tb_cpy_alu_seq.sv
// Bench for cpy_alu_seq at WIDTH=32: arithmetic reference model with expected-result queue, checked every cycle, plus directed literal vectors.
module tb_cpy_alu_seq;
    import cpy_alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (W - 1));

    logic         elk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   sel = 3'b000;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         in_ready, out_valid, z, c, v;
    logic [W-1:0] res;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
        int           due;
    } exp_t;
    exp_t q[$];

    cpy_alu_seq #(.WIDTH(W)) dut (
        .elk       (elk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    always #5 elk = ~elk;
    always @(posedge elk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: what the result must be, from the arithmetic definition of each op.
    function automatic void model(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic fz, output logic fc,
                                  output logic fv, output int lat);
        longint sa, sb, sr;
        logic [63:0] p;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; fc = 1'b0; fv = 1'b0; lat = 1;
        case (s)
            OP_ADD: begin
                p  = 64'(a) + 64'(b);
                r  = p[W-1:0];
                fc = (p >= (64'd1 << W));
                sr = sa + sb;
                fv = (sr > SMAX) || (sr < SMIN);
            end
            OP_SUB: begin
                r  = a - b;
                fc = (a < b);
                sr = sa - sb;
                fv = (sr > SMAX) || (sr < SMIN);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOT: r = ~a;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                n   = int'(b % W);
                r   = a << n;
                fc  = (n == 0) ? 1'b0 : a[W-n];
                lat = n + 1;
            end
            default: begin
`ifdef CPY_ALU_MUL_EN
                p   = 64'(a) * 64'(b);
                r   = p[W-1:0];
                fc  = (p[63:W] != '0);
                fv  = fc;
                lat = W + 1;
`endif
            end
        endcase
        fz = (r == '0);
    endfunction

    // Per-cycle compare against the model queue.
    always @(negedge elk) begin
        logic exp_ir, exp_ov;
        exp_t e;
        logic [W-1:0] mr;
        logic mz, mc, mv;
        int ml;
        if (rst) begin
            chk("mon_in_ready_rst", in_ready, 0);
            q.delete();
        end else begin
            exp_ov = (q.size() != 0) && (cyc >= q[0].due);
            exp_ir = (q.size() == 0) ? 1'b1 : (exp_ov ? out_ready : 1'b0);
            chk("mon_in_ready", in_ready, exp_ir);
            chk("mon_out_valid", out_valid, exp_ov);
            if (exp_ov && out_valid) begin
                chk("mon_res", res, q[0].r);
                chk("mon_zcv", {z, c, v}, {q[0].z, q[0].c, q[0].v});
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                model(sel, opA, opB, mr, mz, mc, mv, ml);
                e.r = mr; e.z = mz; e.c = mc; e.v = mv; e.due = cyc + ml;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b, output int pcyc);
        logic ok;
        ok = 1'b0;
        pcyc = -1000;
        sel = s; opA = a; opB = b; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge elk);
            if (in_ready) begin
                pcyc = cyc + 1;
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", ok, 1);
        @(posedge elk);
        #1;
        in_valid = 1'b0;
        sel = 3'($urandom);
        opA = $urandom;
        opB = $urandom;
    endtask

    task automatic run_op(input string name, input logic [2:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic ec, input logic ev, input int elat);
        logic [W-1:0] mr;
        logic mz, mc, mv;
        int ml, p, seen, lat;
        model(s, a, b, mr, mz, mc, mv, ml);
        chk({name, "_model_res"}, mr, er);
        chk({name, "_model_zcv"}, {mz, mc, mv}, {ez, ec, ev});
        chk({name, "_model_lat"}, ml, elat);
        send(s, a, b, p);
        seen = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge elk);
            if (out_valid) begin
                seen = cyc;
                break;
            end
        end
        lat = (seen < 0) ? -1 : seen - p + 1;
        chk({name, "_lat"}, lat, elat);
        chk({name, "_res"}, res, er);
        chk({name, "_zcv"}, {z, c, v}, {ez, ec, ev});
        @(posedge elk);
        #1;
    endtask

    initial begin
        int p0, p1, p2;
        rst = 1'b1;
        repeat (2) @(posedge elk);
        #1 rst = 1'b0;
        @(negedge elk);
        chk("reset_res", res, 0);
        chk("reset_zcv", {z, c, v}, 3'b000);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge elk);
        #1;

        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 1);
        run_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 1);
        run_op("sub_brw",  OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 0, 1, 0, 1);
        run_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 1, 1);
        run_op("not",      OP_NOT, 32'h0F0F_0000, 32'h1234_5678, 32'hF0F0_FFFF, 0, 0, 0, 1);
        run_op("shl1",     OP_SHL, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 0, 1, 0, 2);
        run_op("shl0",     OP_SHL, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 0, 0, 0, 1);
        run_op("shl31",    OP_SHL, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 0, 1, 0, 32);
        run_op("shl_hib",  OP_SHL, 32'h4000_0000, 32'h0000_0021, 32'h8000_0000, 0, 0, 0, 2);
`ifdef CPY_ALU_MUL_EN
        run_op("mul_hi",   OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 1, 1, 33);
        run_op("mul_lo",   OP_MUL, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 0, 0, 0, 33);
        run_op("mul_max",  OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0, 1, 1, 33);
`else
        run_op("mul_off",  OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 0, 0, 1);
        run_op("mul_off2", OP_MUL, 32'h0000_1234, 32'h0000_0100, 32'h0000_0000, 1, 0, 0, 1);
`endif

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, p0);
        for (int k = 0; k < 4; k++) begin
            @(negedge elk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_res", res, 32'hF000_F000);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge elk);
        #1;
        out_ready = 1'b1;
        send(OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0000, p1);
        send(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, p2);
        chk("b2b_spacing", p2 - p1, 1);
        @(negedge elk);
        chk("b2b_xor_res", res, 32'h0FF0_0FF0);
        chk("b2b_xor_valid", out_valid, 1);
        repeat (2) @(posedge elk);
        #1;

        // Reset while a long shift is in flight.
        send(OP_SHL, 32'h0000_0001, 32'h0000_0014, p0);
        repeat (4) @(posedge elk);
        #1 rst = 1'b1;
        @(posedge elk);
        #1 rst = 1'b0;
        @(negedge elk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_res", res, 0);
        chk("rst_mid_zcv", {z, c, v}, 3'b000);
        chk("rst_mid_in_ready", in_ready, 1);
        @(posedge elk);
        #1;
        run_op("shl20", OP_SHL, 32'h0000_0001, 32'h0000_0014, 32'h0010_0000, 0, 0, 0, 21);
        run_op("xor_z", OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1, 0, 0, 1);

        repeat (3) @(posedge elk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
